present_key_schedule: RTL and testbench

Sequential PRESENT-80 key schedule. It holds the 80-bit key register and produces the 64-bit round key for the current round, advancing one round per request. It sits directly upstream of the combinational PRESENT next-state (round) function and drives that block's 64-bit key input. The round controller loads the user key once per block and pulses a step request each round.

---
 rtl/present_pkg.sv | 17 +
 rtl/present_sbox.sv | 11 +
 rtl/present_key_schedule.sv | 60 ++++++
 tb/tb_present_key_schedule.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT constants and S-box table used by the key schedule and round function.
package present_pkg;

  localparam int unsigned KEY_W  = 80;
  localparam int unsigned RK_W   = 64;
  localparam int unsigned BLK_W  = 64;
  localparam int unsigned ROUNDS = 32;
  localparam int unsigned RND_W  = 6;

  // Nibble n of the table is S(n): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_sbox.sv
// PRESENT 4-bit S-box, purely combinational.
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = sbox_lookup(i_x);

endmodule

// File: rtl/present_key_schedule.sv
// PRESENT-80 key schedule: holds the key register and steps one round key per request.
module present_key_schedule #(
  parameter int unsigned KEY_W  = present_pkg::KEY_W,
  parameter int unsigned RK_W   = present_pkg::RK_W,
  parameter int unsigned ROUNDS = present_pkg::ROUNDS
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inLoad,
  input  logic [KEY_W-1:0] inKey,
  input  logic             inNext,
  output logic [RK_W-1:0]  outRoundKey,
  output logic [5:0]       outRound,
  output logic             outValid,
  output logic             outLast
);

  localparam logic [5:0] LP_LAST_ROUND = 6'(ROUNDS);

  logic [KEY_W-1:0] r_key;
  logic [5:0]       r_round;
  logic             r_valid;

  logic [KEY_W-1:0] w_rot;
  logic [3:0]       w_sbox;
  logic [KEY_W-1:0] w_next_key;
  logic             w_step;

  // Rotate left by 61, substitute the top nibble, then fold in the pre-increment round count.
  assign w_rot = {r_key[18:0], r_key[79:19]};

  present_sbox u_sbox (
    .i_x (w_rot[79:76]),
    .o_y (w_sbox)
  );

  assign w_next_key = {w_sbox, w_rot[75:20], w_rot[19:15] ^ r_round[4:0], w_rot[14:0]};
  assign w_step     = inNext && r_valid && (r_round != LP_LAST_ROUND);

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
    end else if (inLoad) begin
      r_key   <= inKey;
      r_round <= 6'd1;
      r_valid <= 1'b1;
    end else if (w_step) begin
      r_key   <= w_next_key;
      r_round <= r_round + 6'd1;
    end
  end

  assign outRoundKey = r_key[KEY_W-1 -: RK_W];
  assign outRound    = r_round;
  assign outValid    = r_valid;
  assign outLast     = (r_round == LP_LAST_ROUND);

endmodule

// File: tb/tb_present_key_schedule.sv
// Directed self-checking bench for present_key_schedule.
module tb_present_key_schedule;

  logic        inClk = 1'b0;
  logic        inRst;
  logic        inLoad;
  logic [79:0] inKey;
  logic        inNext;
  logic [63:0] outRoundKey;
  logic [5:0]  outRound;
  logic        outValid;
  logic        outLast;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [79:0] mk;
  logic [5:0]  mr;

  present_key_schedule #(.KEY_W(80), .RK_W(64), .ROUNDS(32)) dut (
    .inClk       (inClk),
    .inRst       (inRst),
    .inLoad      (inLoad),
    .inKey       (inKey),
    .inNext      (inNext),
    .outRoundKey (outRoundKey),
    .outRound    (outRound),
    .outValid    (outValid),
    .outLast     (outLast)
  );

  always #5 inClk = ~inClk;

  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] ref_step(input logic [79:0] k, input logic [5:0] r);
    logic [79:0] t;
    for (int i = 0; i < 80; i++) t[(i + 61) % 80] = k[i];
    t[79:76] = ref_sbox(t[79:76]);
    for (int j = 0; j < 5; j++) t[15 + j] = t[15 + j] ^ r[j];
    return t;
  endfunction

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] key, input logic [5:0] rnd,
                         input logic vld, input logic lst);
    chk({tag, ".key"},   outRoundKey, key);
    chk({tag, ".round"}, 64'(outRound), 64'(rnd));
    chk({tag, ".valid"}, 64'(outValid), 64'(vld));
    chk({tag, ".last"},  64'(outLast),  64'(lst));
  endtask

  initial begin
    inRst = 1'b1; inLoad = 1'b0; inKey = '0; inNext = 1'b0;
    #1;
    chk_all("reset_init", 64'h0, 6'd0, 1'b0, 1'b0);
    tick();
    inRst = 1'b0;
    tick();

    // Zero key: hand-derived first three round keys.
    inLoad = 1'b1; inKey = 80'h0;
    tick();
    inLoad = 1'b0;
    chk_all("zero_k1", 64'h0000000000000000, 6'd1, 1'b1, 1'b0);
    inNext = 1'b1;
    tick();
    chk_all("zero_k2", 64'hC000000000000000, 6'd2, 1'b1, 1'b0);
    tick();
    inNext = 1'b0;
    chk_all("zero_k3", 64'h5000180000000001, 6'd3, 1'b1, 1'b0);

    // Full run against the reference step model.
    inLoad = 1'b1; inKey = 80'h0123_4567_89AB_CDEF_F00D;
    tick();
    inLoad = 1'b0;
    mk = 80'h0123_4567_89AB_CDEF_F00D; mr = 6'd1;
    chk_all("full_k1", mk[79:16], mr, 1'b1, 1'b0);
    inNext = 1'b1;
    for (int n = 0; n < 31; n++) begin
      tick();
      mk = ref_step(mk, mr);
      mr = mr + 6'd1;
      chk("full.key", outRoundKey, mk[79:16]);
      chk("full.round", 64'(outRound), 64'(mr));
      chk("full.last", 64'(outLast), 64'(mr == 6'd32));
    end
    tick();
    tick();
    inNext = 1'b0;
    chk_all("full_hold", mk[79:16], 6'd32, 1'b1, 1'b1);

    // Load wins over a simultaneous step at round 5.
    inLoad = 1'b1; inKey = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    inLoad = 1'b0; inNext = 1'b1;
    repeat (4) tick();
    chk("prio_pre.round", 64'(outRound), 64'd5);
    inLoad = 1'b1; inKey = 80'h0;
    tick();
    inLoad = 1'b0; inNext = 1'b0;
    chk_all("prio", 64'h0, 6'd1, 1'b1, 1'b0);

    // Reload mid-run.
    inLoad = 1'b1; inKey = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    inLoad = 1'b0; inNext = 1'b1;
    repeat (3) tick();
    inNext = 1'b0;
    mk = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    for (int n = 1; n <= 3; n++) mk = ref_step(mk, 6'(n));
    chk_all("reload_pre", mk[79:16], 6'd4, 1'b1, 1'b0);
    inLoad = 1'b1; inKey = 80'h0;
    tick();
    inLoad = 1'b0;
    chk_all("reload_k1", 64'h0, 6'd1, 1'b1, 1'b0);
    inNext = 1'b1;
    tick();
    inNext = 1'b0;
    chk_all("reload_k2", 64'hC000000000000000, 6'd2, 1'b1, 1'b0);

    // Asynchronous reset between edges at round 7.
    inLoad = 1'b1; inKey = 80'h0;
    tick();
    inLoad = 1'b0; inNext = 1'b1;
    repeat (6) tick();
    inNext = 1'b0;
    chk("rst_pre.round", 64'(outRound), 64'd7);
    @(negedge inClk);
    inRst = 1'b1;
    #1;
    chk_all("rst_async", 64'h0, 6'd0, 1'b0, 1'b0);
    tick();
    inRst = 1'b0;
    inNext = 1'b1;
    repeat (2) tick();
    inNext = 1'b0;
    chk_all("rst_next_ignored", 64'h0, 6'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
